sram_cmd_ctl: RTL and testbench

- Downstream consumer of the Wishbone slave's internal command bus (cmd_val/cmd_adr/cmd_we/cmd_sel/cmd_dat).
- Returns read data through rd_ack/rd_dat.
- Decodes each command to either the toy SRAM array port or a small local register file.
- Sequences array reads with fixed latency and performs read-modify-write for partial-byte writes, because the array has no byte enables.

---
 rtl/sram_cmd_ctl_pkg.sv | 25 ++
 rtl/sram_rmw_merge.sv | 19 +
 rtl/sram_cmd_ctl.sv | 165 ++++++++++++++++
 tb/tb_sram_cmd_ctl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_cmd_ctl_pkg.sv
// Shared definitions for the SRAM command controller: FSM encoding,
// address-decode constants and register-file offsets.
package sram_cmd_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    MERGE_WR = 3'd2,
    ACK      = 3'd3,
    HOLD     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_RD_CNT = 2'd1,
    REG_WR_CNT = 2'd2,
    REG_NONE   = 2'd3
  } reg_off_e;

  localparam int         REGION_BIT = 23;
  localparam logic       CTRL_RST   = 1'b1;
  localparam logic [3:0] SEL_ALL    = 4'hF;
  localparam logic [3:0] SEL_NONE   = 4'h0;

endpackage

// File: rtl/sram_rmw_merge.sv
// Byte-wise merge for read-modify-write: selected bytes come from the new
// data, the rest keep the word read back from the array.
module sram_rmw_merge (
  input  logic [31:0] old_dat_i,
  input  logic [31:0] new_dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  always_comb begin
    // NOTE: assign a default before the conditional updates so no path
    // leaves merged_o unassigned, which would infer a latch.
    merged_o = old_dat_i;
    for (int b = 0; b < 4; b++) begin
      if (sel_i[b]) merged_o[8*b +: 8] = new_dat_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/sram_cmd_ctl.sv
// Command-bus consumer: decodes each command to the SRAM array or the local
// register file, sequences fixed-latency reads and partial-write RMW.
module sram_cmd_ctl
  import sram_cmd_ctl_pkg::*;
#(
  parameter int ADR_W  = 6,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_val,
  input  logic [31:0]      cmd_adr,
  input  logic             cmd_we,
  input  logic [3:0]       cmd_sel,
  input  logic [31:0]      cmd_dat,
  output logic             rd_ack,
  output logic [31:0]      rd_dat,
  output logic             sram_re,
  output logic             sram_we,
  output logic [ADR_W-1:0] sram_adr,
  output logic [31:0]      sram_wdat,
  input  logic [31:0]      sram_rdat,
  output logic             busy
);

  state_e           state_q;
  logic [2:0]       lat_q;
  logic             rmw_q;
  logic [3:0]       sel_q;
  logic [31:0]      dat_q;
  logic             ctrl_en_q;
  logic [15:0]      rd_cnt_q;
  logic [15:0]      wr_cnt_q;
  logic             rd_ack_q;
  logic [31:0]      rd_dat_q;
  logic             sram_re_q;
  logic             sram_we_q;
  logic [ADR_W-1:0] sram_adr_q;
  logic [31:0]      sram_wdat_q;
  logic [31:0]      merged_d;
  logic [31:0]      reg_rdat_d;
  reg_off_e         reg_off;

  // Address bits outside the region bit, word index and register offset.
  logic unused_adr;
  assign unused_adr = ^{cmd_adr[31:24], cmd_adr[22:ADR_W+2], cmd_adr[1:0]};

  assign reg_off = reg_off_e'(cmd_adr[3:2]);

  always_comb begin
    reg_rdat_d = '0;
    case (reg_off)
      REG_CTRL:   reg_rdat_d = {31'b0, ctrl_en_q};
      REG_RD_CNT: reg_rdat_d = {16'b0, rd_cnt_q};
      REG_WR_CNT: reg_rdat_d = {16'b0, wr_cnt_q};
      default:    reg_rdat_d = '0;
    endcase
  end

  sram_rmw_merge u_merge (
    .old_dat_i (sram_rdat),
    .new_dat_i (dat_q),
    .sel_i     (sel_q),
    .merged_o  (merged_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      rmw_q       <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      ctrl_en_q   <= CTRL_RST;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      rd_ack_q    <= 1'b0;
      rd_dat_q    <= '0;
      sram_re_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_adr_q  <= '0;
      sram_wdat_q <= '0;
    end else begin
      // NOTE: non-blocking defaults here make every strobe below a
      // single-cycle pulse; later assignments in the same block override.
      rd_ack_q  <= 1'b0;
      sram_re_q <= 1'b0;
      sram_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_val) begin
            sram_adr_q <= cmd_adr[ADR_W+1:2];
            sel_q      <= cmd_sel;
            dat_q      <= cmd_dat;
            state_q    <= HOLD;
            if (cmd_adr[REGION_BIT]) begin
              if (cmd_we) begin
                case (reg_off)
                  REG_CTRL:   ctrl_en_q <= cmd_dat[0];
                  REG_RD_CNT: rd_cnt_q  <= cmd_dat[15:0];
                  REG_WR_CNT: wr_cnt_q  <= cmd_dat[15:0];
                  default:    ;
                endcase
              end else begin
                rd_ack_q <= 1'b1;
                rd_dat_q <= reg_rdat_d;
                state_q  <= ACK;
              end
            end else if (!ctrl_en_q) begin
              // Array disabled: reads complete immediately with zero data.
              if (!cmd_we) begin
                rd_ack_q <= 1'b1;
                rd_dat_q <= '0;
                state_q  <= ACK;
              end
            end else if (!cmd_we) begin
              sram_re_q <= 1'b1;
              rd_cnt_q  <= rd_cnt_q + 16'd1;
              lat_q     <= 3'(RD_LAT);
              rmw_q     <= 1'b0;
              state_q   <= RD_WAIT;
            end else if (cmd_sel == SEL_ALL) begin
              sram_we_q   <= 1'b1;
              sram_wdat_q <= cmd_dat;
              wr_cnt_q    <= wr_cnt_q + 16'd1;
            end else if (cmd_sel != SEL_NONE) begin
              sram_re_q <= 1'b1;
              lat_q     <= 3'(RD_LAT);
              rmw_q     <= 1'b1;
              state_q   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_q == '0) begin
            if (rmw_q) begin
              sram_we_q   <= 1'b1;
              sram_wdat_q <= merged_d;
              wr_cnt_q    <= wr_cnt_q + 16'd1;
              state_q     <= MERGE_WR;
            end else begin
              rd_ack_q <= 1'b1;
              rd_dat_q <= sram_rdat;
              state_q  <= ACK;
            end
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        MERGE_WR, ACK: state_q <= HOLD;
        HOLD:          if (!cmd_val) state_q <= IDLE;
        default:       state_q <= IDLE;
      endcase
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_dat    = rd_dat_q;
  assign sram_re   = sram_re_q;
  assign sram_we   = sram_we_q;
  assign sram_adr  = sram_adr_q;
  assign sram_wdat = sram_wdat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_cmd_ctl.sv
// Randomized bench for sram_cmd_ctl: an SRAM emulator with fixed read latency
// plus a transaction-level model predicting strobes, data and counters.
module tb_sram_cmd_ctl;

  localparam int ADR_W  = 6;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << ADR_W;
  localparam int WIN    = RD_LAT + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_val;
  logic [31:0]      cmd_adr;
  logic             cmd_we;
  logic [3:0]       cmd_sel;
  logic [31:0]      cmd_dat;
  logic             rd_ack;
  logic [31:0]      rd_dat;
  logic             sram_re;
  logic             sram_we;
  logic [ADR_W-1:0] sram_adr;
  logic [31:0]      sram_wdat;
  logic [31:0]      sram_rdat;
  logic             busy;

  always #5 clk = ~clk;

  sram_cmd_ctl #(.ADR_W(ADR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_val   (cmd_val),
    .cmd_adr   (cmd_adr),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_dat   (cmd_dat),
    .rd_ack    (rd_ack),
    .rd_dat    (rd_dat),
    .sram_re   (sram_re),
    .sram_we   (sram_we),
    .sram_adr  (sram_adr),
    .sram_wdat (sram_wdat),
    .sram_rdat (sram_rdat),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM emulator: data appears RD_LAT cycles after the sram_re cycle,
  // noise otherwise so mistimed sampling shows up.
  logic        mem_init;
  logic [31:0] sram_mem [DEPTH];
  logic        vld_pipe [RD_LAT];
  logic [31:0] dat_pipe [RD_LAT];
  logic [31:0] noise_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
    end else if (sram_we) begin
      sram_mem[sram_adr] <= sram_wdat;
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      vld_pipe[i] <= vld_pipe[i-1];
      dat_pipe[i] <= dat_pipe[i-1];
    end
    vld_pipe[0] <= sram_re;
    dat_pipe[0] <= sram_mem[sram_adr];
    noise_q     <= $urandom;
  end

  assign sram_rdat = (vld_pipe[RD_LAT-1] === 1'b1) ? dat_pipe[RD_LAT-1] : noise_q;

  // Transaction-level reference model.
  logic [31:0] m_mem [DEPTH];
  logic        m_en;
  logic [15:0] m_rd_cnt;
  logic [15:0] m_wr_cnt;
  logic [31:0] m_last_rd;

  task automatic model_reset();
    m_en      = 1'b1;
    m_rd_cnt  = '0;
    m_wr_cnt  = '0;
    m_last_rd = '0;
  endtask

  // Called at a negedge; returns at the negedge after cmd_val has been low one cycle.
  task automatic exec_cmd(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, input int extra);
    int          re_k, we_k, ack_k, idx;
    logic [31:0] exp_wdat, exp_rdat;
    re_k = 0; we_k = 0; ack_k = 0;
    exp_wdat = '0; exp_rdat = '0;
    idx = int'(adr[ADR_W+1:2]);
    if (adr[23]) begin
      if (we) begin
        case (adr[3:2])
          2'd0:    m_en     = dat[0];
          2'd1:    m_rd_cnt = dat[15:0];
          2'd2:    m_wr_cnt = dat[15:0];
          default: ;
        endcase
      end else begin
        ack_k = 1;
        case (adr[3:2])
          2'd0:    exp_rdat = {31'b0, m_en};
          2'd1:    exp_rdat = {16'b0, m_rd_cnt};
          2'd2:    exp_rdat = {16'b0, m_wr_cnt};
          default: exp_rdat = '0;
        endcase
      end
    end else if (!m_en) begin
      if (!we) ack_k = 1;
    end else if (!we) begin
      re_k = 1;
      ack_k = RD_LAT + 2;
      exp_rdat = m_mem[idx];
      m_rd_cnt++;
    end else if (sel == 4'hF) begin
      we_k = 1;
      exp_wdat = dat;
    end else if (sel != 4'h0) begin
      re_k = 1;
      we_k = RD_LAT + 2;
      exp_wdat = m_mem[idx];
      for (int b = 0; b < 4; b++) if (sel[b]) exp_wdat[8*b +: 8] = dat[8*b +: 8];
    end
    if (we_k != 0) begin
      m_mem[idx] = exp_wdat;
      m_wr_cnt++;
    end
    if (ack_k != 0) m_last_rd = exp_rdat;

    cmd_val = 1'b1; cmd_adr = adr; cmd_we = we; cmd_sel = sel; cmd_dat = dat;
    for (int k = 1; k <= WIN + extra; k++) begin
      @(negedge clk);
      check("strobes{re,we,ack}", {29'b0, sram_re, sram_we, rd_ack},
            {29'b0, k == re_k, k == we_k, k == ack_k});
      check("busy_high", {31'b0, busy}, 32'd1);
      if (k == re_k || k == we_k) check("sram_adr", {{(32-ADR_W){1'b0}}, sram_adr}, 32'(idx));
      if (k == we_k) check("sram_wdat", sram_wdat, exp_wdat);
      if (k == ack_k) check("rd_dat", rd_dat, exp_rdat);
    end
    cmd_val = 1'b0; cmd_adr = $urandom; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
    cmd_dat = $urandom;
    @(negedge clk);
    check("busy_released", {31'b0, busy}, 32'd0);
    check("rd_dat_hold", rd_dat, m_last_rd);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    logic        w;
    int          r;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = init_word(i);
    model_reset();
    rst = 1'b1; mem_init = 1'b1;
    cmd_val = 1'b0; cmd_adr = '0; cmd_we = 1'b0; cmd_sel = '0; cmd_dat = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'b0, rd_ack, sram_re, sram_we, busy}, 32'd0);
    check("reset_rd_dat", rd_dat, 32'd0);
    check("reset_wdat", sram_wdat, 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    exec_cmd(32'h0080_0000, 1'b0, 4'h0, 32'h0, 0);          // CTRL reads 1
    exec_cmd(32'h0080_0004, 1'b0, 4'h0, 32'h0, 0);          // RD_CNT reads 0
    exec_cmd(32'h0000_0010, 1'b1, 4'hF, 32'hA5A5_1234, 0);  // full write
    exec_cmd(32'h0080_0008, 1'b0, 4'h0, 32'h0, 0);          // WR_CNT = 1
    exec_cmd(32'h0000_0010, 1'b0, 4'h0, 32'h0, 0);          // read back
    exec_cmd(32'h0080_0004, 1'b0, 4'h0, 32'h0, 0);          // RD_CNT = 1
    exec_cmd(32'h0000_0010, 1'b1, 4'h2, 32'h0000_7700, 0);  // partial write
    exec_cmd(32'h0000_0010, 1'b0, 4'h0, 32'h0, 0);
    check("rmw_result_literal", m_last_rd, 32'hA5A5_7734);
    exec_cmd(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1);          // long hold, one read
    exec_cmd(32'h0000_0020, 1'b0, 4'h0, 32'h0, 0);
    exec_cmd(32'h0000_0014, 1'b1, 4'h0, 32'hFFFF_FFFF, 0);  // sel 0000 write
    exec_cmd(32'h0080_0000, 1'b1, 4'h0, 32'h0, 0);          // CTRL = 0
    exec_cmd(32'h0000_0010, 1'b0, 4'h0, 32'h0, 0);          // disabled read
    exec_cmd(32'h0000_0018, 1'b1, 4'hF, 32'h1111_2222, 0);  // dropped write
    exec_cmd(32'h0080_0000, 1'b1, 4'h0, 32'h1, 0);          // CTRL = 1
    exec_cmd(32'h0000_0018, 1'b0, 4'h0, 32'h0, 0);
    exec_cmd(32'h0080_0008, 1'b1, 4'h3, 32'h0000_FFFF, 0);  // WR_CNT = FFFF
    exec_cmd(32'h0080_0008, 1'b0, 4'h0, 32'h0, 0);
    exec_cmd(32'h0000_0024, 1'b1, 4'hF, 32'hCAFE_F00D, 0);
    exec_cmd(32'h0080_0008, 1'b0, 4'h0, 32'h0, 0);          // wrapped to 0
    exec_cmd(32'h0080_000C, 1'b1, 4'hF, 32'hFFFF_FFFF, 0);  // unmapped write
    exec_cmd(32'h0080_000C, 1'b0, 4'h0, 32'h0, 0);

    // Reset while a read waits in RD_WAIT.
    cmd_val = 1'b1; cmd_adr = 32'h0000_0014; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_dat = '0;
    @(negedge clk);
    check("rst_test_re", {31'b0, sram_re}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {28'b0, rd_ack, sram_re, sram_we, busy}, 32'd0);
    check("rst_mid_rd_dat", rd_dat, 32'd0);
    check("rst_mid_adr", {{(32-ADR_W){1'b0}}, sram_adr}, 32'd0);
    rst = 1'b0; cmd_val = 1'b0;
    model_reset();
    for (int k = 0; k < RD_LAT + 3; k++) begin
      @(negedge clk);
      check("rst_after_quiet", {29'b0, sram_re, sram_we, rd_ack}, 32'd0);
    end
    exec_cmd(32'h0080_0004, 1'b0, 4'h0, 32'h0, 0);
    exec_cmd(32'h0080_0000, 1'b0, 4'h0, 32'h0, 0);
    exec_cmd(32'h0000_0014, 1'b0, 4'h0, 32'h0, 0);

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom & ~32'h0080_0000;
      w = 1'b0;
      s = 4'($urandom);
      case (r)
        0, 1: begin
          a = a | 32'h0080_0000;
          w = 1'($urandom);
        end
        2, 3, 4: w = 1'b0;
        5, 6: begin w = 1'b1; s = 4'hF; end
        7, 8: begin w = 1'b1; s = 4'($urandom_range(1, 14)); end
        default: begin w = 1'b1; s = 4'h0; end
      endcase
      if (a[23] && w && a[3:2] == 2'd0) begin
        exec_cmd(a, w, s, {$urandom_range(0, 65535), 15'b0, 1'($urandom_range(0, 3) != 0)}, 0);
      end else begin
        exec_cmd(a, w, s, $urandom, $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
